// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared state encoding and counter sizing for shift_seq
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Counter must hold 0..SIZE.
  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - load/shift sequencer for a right-shift register
// Optional SHIFT_SEQ_HOLD_EN adds a hold input that stalls shifting.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
`ifdef SHIFT_SEQ_HOLD_EN
  input  logic            hold,
`endif
  output logic [SIZE-1:0] sr_din,
  output logic            sr_pl,
  output logic            sr_en,
  output logic            sr_si,
  output logic            bit_valid,
  output logic            bit_last,
  output logic            busy,
  output logic            done
);

  localparam int CW = cnt_width(SIZE);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          stall;
  logic          last_shift;
  logic          accept;

`ifdef SHIFT_SEQ_HOLD_EN
  // hold only matters while shifting; it gates sr_en in the same cycle.
  assign stall = hold && (state == SHIFT);
`else
  assign stall = 1'b0;
`endif

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign sr_pl      = (state == LOAD);
  assign sr_en      = (state == SHIFT) && !stall;
  assign sr_si      = 1'b0;
  assign accept     = in_ready && in_valid;
  assign last_shift = sr_en && (cnt == CW'(SIZE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sr_din <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sr_din <= in_data;
            cnt    <= '0;
            state  <= LOAD;
          end
        end
        LOAD:  state <= SHIFT;
        SHIFT: begin
          if (sr_en) begin
            cnt <= cnt + CW'(1);
            if (last_shift) state <= FLUSH;
          end
        end
        FLUSH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The register's so lags sr_en by one edge, so the qualifiers do too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      bit_valid <= sr_en;
      bit_last  <= last_shift;
      done      <= last_shift;
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - scoreboard bench for shift_seq (SIZE=4 and SIZE=8 instances)
module tb_shift_seq;
  localparam int S = 4;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [S-1:0] in_data;
  logic in_valid, in_ready, hold;
  logic [S-1:0] sr_din;
  logic sr_pl, sr_en, sr_si, bit_valid, bit_last, busy, done;

  logic [7:0] in_data8;
  logic in_valid8, in_ready8, hold8;
  logic [7:0] sr_din8;
  logic sr_pl8, sr_en8, sr_si8, bv8, bl8, busy8, done8;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int n_en = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  shift_seq #(.SIZE(S)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef SHIFT_SEQ_HOLD_EN
    .hold(hold),
`endif
    .sr_din(sr_din), .sr_pl(sr_pl), .sr_en(sr_en), .sr_si(sr_si),
    .bit_valid(bit_valid), .bit_last(bit_last), .busy(busy), .done(done)
  );

  shift_seq #(.SIZE(8)) dut8 (
    .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
`ifdef SHIFT_SEQ_HOLD_EN
    .hold(hold8),
`endif
    .sr_din(sr_din8), .sr_pl(sr_pl8), .sr_en(sr_en8), .sr_si(sr_si8),
    .bit_valid(bv8), .bit_last(bl8), .busy(busy8), .done(done8)
  );

  // Behavioural right-shift registers with registered serial out.
  logic [S-1:0] m_sr;
  logic m_so;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sr <= '0;
      m_so <= 1'b0;
    end else if (sr_pl) begin
      m_sr <= sr_din;
    end else if (sr_en) begin
      m_so <= m_sr[0];
      m_sr <= {sr_si, m_sr[S-1:1]};
    end
  end

  logic [7:0] m_sr8;
  logic m_so8;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sr8 <= '0;
      m_so8 <= 1'b0;
    end else if (sr_pl8) begin
      m_sr8 <= sr_din8;
    end else if (sr_en8) begin
      m_so8 <= m_sr8[0];
      m_sr8 <= {sr_si8, m_sr8[7:1]};
    end
  end

  // Scoreboard: push bits on handshake, pop on every bit_valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) n_done++;
      if (sr_en) n_en++;
      n_cmp++;
      if ((sr_pl && sr_en) !== 1'b0) begin
        n_err++;
        $display("FAIL pl_en_overlap: got pl=%b en=%b expected not both", sr_pl, sr_en);
      end
      if (bit_valid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL sb_underflow: got bit_valid=1 expected no pending bit");
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({m_so, bit_last, done} !== {e.b, e.last, e.last}) begin
            n_err++;
            $display("FAIL sb_bit: got so/last/done=%b%b%b expected %b%b%b",
                     m_so, bit_last, done, e.b, e.last, e.last);
          end
        end
      end else begin
        n_cmp++;
        if ({bit_last, done} !== 2'b00) begin
          n_err++;
          $display("FAIL idle_flags: got last/done=%b%b expected 00", bit_last, done);
        end
      end
      if (in_valid && in_ready)
        for (int i = 0; i < S; i++) q.push_back('{b: in_data[i], last: (i == S - 1)});
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready && !bit_valid) break;
    end
    n_cmp++;
    if (k == 40) begin
      n_err++;
      $display("FAIL idle_timeout: got busy after 40 cycles expected idle");
    end
  endtask

  task automatic accept_word(input logic [S-1:0] d);
    @(posedge clk); #1;
    in_data = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({in_ready, busy, sr_pl, sr_en, sr_si, bit_valid, bit_last, done, sr_din} !== {8'b1000_0000, 4'h0}) begin
      n_err++;
      $display("FAIL reset_state: got %b expected 10000000_0000",
               {in_ready, busy, sr_pl, sr_en, sr_si, bit_valid, bit_last, done, sr_din});
    end
  endtask

  task automatic test_timing();
    logic [4:0] exp;
    int d0;
    d0 = n_done;
    @(posedge clk); #1;
    in_data = 4'b1011;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= S + 3; k++) begin
      @(negedge clk);
      exp = {k == 1, (k >= 2 && k <= S + 1), (k >= 3 && k <= S + 2), k == S + 2, k == S + 3};
      n_cmp++;
      if ({sr_pl, sr_en, bit_valid, done, in_ready} !== exp) begin
        n_err++;
        $display("FAIL timing_k%0d: got pl/en/bv/done/rdy=%b expected %b",
                 k, {sr_pl, sr_en, bit_valid, done, in_ready}, exp);
      end
    end
    n_cmp++;
    if (n_done - d0 !== 1) begin
      n_err++;
      $display("FAIL timing_done_count: got %0d expected 1", n_done - d0);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    @(posedge clk); #1;
    in_data = 4'hA;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 4'h5;
    for (k = 1; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    n_cmp++;
    if (k !== S + 3) begin
      n_err++;
      $display("FAIL b2b_gap: got second accept at T+%0d expected T+%0d", k, S + 3);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();
    n_cmp++;
    if (q.size() !== 0) begin
      n_err++;
      $display("FAIL b2b_drain: got %0d pending bits expected 0", q.size());
    end
  endtask

  task automatic test_ignore_busy();
    int d0;
    d0 = n_done;
    @(posedge clk); #1;
    in_data = 4'h6;
    in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < S + 2; i++) begin
      #1 in_data = 4'($urandom_range(0, 15));
      @(negedge clk);
      n_cmp++;
      if (sr_din !== 4'h6) begin
        n_err++;
        $display("FAIL busy_din_%0d: got %h expected 6", i, sr_din);
      end
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    wait_idle();
    n_cmp++;
    if (n_done - d0 !== 1) begin
      n_err++;
      $display("FAIL busy_done_count: got %0d expected 1", n_done - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    @(posedge clk); #1;
    in_data = 4'b0110;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    n_cmp++;
    if (sr_en !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: got sr_en=%b expected 1", sr_en);
    end
    rst = 1'b1;
    #1;
    q.delete();
    d0 = n_done;
    n_cmp++;
    if ({in_ready, busy, sr_pl, sr_en, bit_valid, bit_last, done, sr_din} !== {7'b1000000, 4'h0}) begin
      n_err++;
      $display("FAIL rstmid_state: got %b expected 1000000_0000",
               {in_ready, busy, sr_pl, sr_en, bit_valid, bit_last, done, sr_din});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    accept_word(4'b1001);
    wait_idle();
    n_cmp++;
    if (n_done - d0 !== 1) begin
      n_err++;
      $display("FAIL rstmid_done: got %0d expected 1", n_done - d0);
    end
  endtask

`ifdef SHIFT_SEQ_HOLD_EN
  task automatic test_hold();
    int e0, kd;
    e0 = n_en;
    kd = 0;
    @(posedge clk); #1;
    in_data = 4'b1101;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    hold = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_cmp++;
        if (sr_pl !== 1'b1) begin
          n_err++;
          $display("FAIL hold_load: got sr_pl=%b expected 1", sr_pl);
        end
      end
      if (done) kd = k;
      @(posedge clk); #1;
      hold = (k >= 3 && k <= 5);
    end
    n_cmp++;
    if (kd !== S + 5) begin
      n_err++;
      $display("FAIL hold_done_cycle: got T+%0d expected T+%0d", kd, S + 5);
    end
    n_cmp++;
    if (n_en - e0 !== S) begin
      n_err++;
      $display("FAIL hold_en_count: got %0d expected %0d", n_en - e0, S);
    end
  endtask
`endif

  task automatic test_size8();
    logic [7:0] bits;
    int nb, nl, li;
    bits = '0;
    nb = 0;
    nl = 0;
    li = -1;
    @(posedge clk); #1;
    in_data8 = 8'h81;
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bv8) begin
        if (nb < 8) bits[nb] = m_so8;
        if (bl8) begin
          nl++;
          li = nb;
        end
        nb++;
      end
    end
    n_cmp++;
    if (nb !== 8) begin
      n_err++;
      $display("FAIL s8_count: got %0d expected 8", nb);
    end
    n_cmp++;
    if (bits !== 8'h81) begin
      n_err++;
      $display("FAIL s8_bits: got %h expected 81", bits);
    end
    n_cmp++;
    if (nl !== 1 || li !== 7) begin
      n_err++;
      $display("FAIL s8_last: got count=%0d at=%0d expected count=1 at=7", nl, li);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    hold = 1'b0;
    in_data8 = '0;
    in_valid8 = 1'b0;
    hold8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_timing();
    wait_idle();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
`ifdef SHIFT_SEQ_HOLD_EN
    test_hold();
    wait_idle();
`endif
    test_size8();
    n_cmp++;
    if (q.size() !== 0) begin
      n_err++;
      $display("FAIL final_drain: got %0d pending bits expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
# shift_seq

Sequencing controller for the parameterised right-shift register (parallel load `pl`, shift enable `en`, serial in `si`, registered serial out `so`). It accepts parallel words over a valid/ready handshake, drives one load pulse followed by exactly SIZE shift pulses per word, and flags the cycles in which the register's `so` carries a valid bit (LSB first). It sits between a word producer and the shift register, which it owns exclusively.

## Interface
- SIZE, 4, word width and shift count; legal range SIZE >= 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  SIZE  word to serialise; sampled on handshake.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller can accept a word (high only in IDLE).
- hold  in  1  stall shifting (present only with SHIFT_SEQ_HOLD_EN).
- sr_din  out  SIZE  registered copy of the accepted word, to shift register `din`.
- sr_pl  out  1  parallel-load strobe to shift register.
- sr_en  out  1  shift strobe to shift register.
- sr_si  out  1  serial fill bit; constant 0.
- bit_valid  out  1  shift register `so` holds a data bit this cycle.
- bit_last  out  1  qualifies the final bit of the word; only high with bit_valid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse coincident with the last bit.

## Operation
- FSM states: IDLE, LOAD, SHIFT, FLUSH.
- IDLE: in_ready=1. On in_valid: latch in_data into sr_din, clear bit counter, go to LOAD.
- LOAD: sr_pl=1 for exactly one cycle, then go to SHIFT. in_valid ignored.
- SHIFT: sr_en=1 each cycle not stalled; counter increments per asserted sr_en. The cycle sr_en is asserted with count == SIZE-1, go to FLUSH.
- FLUSH: one cycle; bit_valid=1, bit_last=1, done=1; go to IDLE.
- bit_valid is sr_en delayed one register stage (matches the register's output latency); bit_last is high for the bit produced by the SIZE-th sr_en.
- sr_pl and sr_en are never high in the same cycle.
- sr_din is held constant from acceptance until the next acceptance.
- Bit counter width: $clog2(SIZE+1); no wrap occurs in legal operation.
- Reset, asynchronous at any point including mid-word: state=IDLE, counter=0, sr_din=0, sr_pl=sr_en=bit_valid=bit_last=done=busy=0, sr_si=0, in_ready=1. A partially shifted word is discarded and no done is issued.

## Timing
- Handshake at edge T (in_valid & in_ready): sr_pl high in cycle T+1; sr_en high in cycles T+2..T+SIZE+1; bit_valid high in T+3..T+SIZE+2; done/bit_last in T+SIZE+2; in_ready high again in T+SIZE+3.
- Throughput without stalls: one word per SIZE+3 cycles. No back-to-back acceptance.
- sr_pl, sr_en, in_ready, busy are decoded from state; bit_valid, bit_last, done are registered.
- in_valid asserted while busy: held off by in_ready=0; the producer must keep in_data stable until acceptance.

## Configuration
- SHIFT_SEQ_HOLD_EN defined: `hold` port exists. In SHIFT, hold=1 forces sr_en=0 combinationally in the same cycle and freezes the counter; bit_valid drops one cycle later. hold is ignored in IDLE, LOAD and FLUSH.
- Undefined: no `hold` port; SHIFT always shifts; latency fixed as above.

## Structure
- Package shift_seq_pkg: state typedef (IDLE, LOAD, SHIFT, FLUSH) with fixed encodings 2'd0..2'd3, and the counter-width function/constant derived from SIZE.
- Single module with the counter inline; no sub-module. The shift register is instantiated by the parent, not inside this block.

## Test plan
- Reset mid-SHIFT: assert rst during second sr_en -> all outputs at reset values immediately, in_ready=1, no done; the next word serialises correctly.
- SIZE=4, in_data=4'b1011 accepted at T -> sr_pl at T+1, sr_en at T+2..T+5, so = 1,1,0,1 with bit_valid at T+3..T+6, done and bit_last at T+6, in_ready at T+7.
- in_valid held high across two words 4'hA, 4'h5 -> second accepted exactly at T+7; serial stream 0,1,0,1 then 1,0,1,0; no overlap of sr_pl with sr_en.
- in_valid asserted during SHIFT with changing in_data -> ignored; sr_din stable; only one done per accepted word.
- SHIFT_SEQ_HOLD_EN, hold=1 for 3 cycles after the second sr_en -> exactly 4 sr_en total, bit sequence unchanged, done delayed by 3 cycles; hold during LOAD has no effect.
- SIZE=8, in_data=8'h81 -> 8 bit_valid cycles, bits 1,0,0,0,0,0,0,1, bit_last on the 8th only.
